// File: rtl/root_engine_arbiter.sv
// root_engine_arbiter
// Shares one fixed-point root engine (10-bit radicand, 3-bit degree, Q10.10
// result) among N_REQ requesters with a round-robin grant. The granted
// operands are latched and held on the engine inputs for the whole
// computation. Each result is returned as a one-cycle pulse tagged with the
// requester ID.
// Optional feature: define ROOT_ARB_TIMEOUT_EN to add a BUSY watchdog.
// When it expires, the arbiter answers with rsp_err=1 and rsp_data=20'hFFFFF.
module root_engine_arbiter #(
   parameter int N_REQ          = 4,
   parameter int ID_W           = 2,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [N_REQ*10-1:0]  req_radicand,
   input  logic [N_REQ*3-1:0]   req_degree,
   output logic                 rsp_valid,
   output logic [ID_W-1:0]      rsp_id,
   output logic [19:0]          rsp_data,
   output logic                 rsp_err,
   output logic                 eng_in_valid,
   output logic [9:0]           eng_in_data_1,
   output logic [2:0]           eng_in_data_2,
   input  logic                 eng_out_valid,
   input  logic [19:0]          eng_out_data,
   output logic                 busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_BUSY  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   // Reject configurations whose ID width cannot index the requesters.
   if (ID_W != $clog2(N_REQ) || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("root_engine_arbiter: ID_W must equal clog2(N_REQ) and TIMEOUT_CYCLES must be >= 2");
   end

   logic [1:0]       state_q, state_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [9:0]       rad_q, rad_d;
   logic [2:0]       deg_q, deg_d;
   logic [19:0]      data_q, data_d;
   logic             err_q, err_d;

   logic             grant_any;
   logic [ID_W-1:0]  grant_idx;
   logic             accept;
   logic [9:0]       grant_rad;
   logic [2:0]       grant_deg;

`ifdef ROOT_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_hit;

   // Watchdog: cleared while issuing, so it starts at zero on BUSY entry.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_ISSUE) begin
         cnt_d = '0;
      end else if (state_q == S_BUSY) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign timeout_hit = (state_q == S_BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Watchdog counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   // Round-robin search that starts just after the last granted requester.
   always_comb begin
      int          idx;
      logic [ID_W-1:0] cand;
      grant_any = 1'b0;
      grant_idx = '0;
      idx       = 0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         cand = ID_W'(idx);
         if (!grant_any && req_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // One-hot grant, offered only in IDLE and never during reset.
   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && grant_any && !rst) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign accept    = |req_ready;
   assign grant_rad = req_radicand[int'(grant_idx)*10 +: 10];
   assign grant_deg = req_degree[int'(grant_idx)*3 +: 3];

   // Transaction sequencing: accept, issue, wait for the engine, respond.
   always_comb begin
      // NOTE: every variable gets a hold-value default up front so no path leaves it unassigned (no latches).
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      rad_d   = rad_q;
      deg_d   = deg_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               ptr_d = grant_idx;
               id_d  = grant_idx;
               rad_d = grant_rad;
               deg_d = grant_deg;
               if (grant_deg == 3'd0) begin
                  data_d  = '0;
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: state_d = S_BUSY;
         S_BUSY: begin
            if (eng_out_valid) begin
               data_d  = eng_out_data;
               err_d   = 1'b0;
               state_d = S_RESP;
            end
`ifdef ROOT_ARB_TIMEOUT_EN
            else if (timeout_hit) begin
               data_d  = 20'hFFFFF;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
`endif
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and operand/result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= ID_W'(N_REQ - 1);
         id_q    <= '0;
         rad_q   <= '0;
         deg_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         rad_q   <= rad_d;
         deg_q   <= deg_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign rsp_valid     = (state_q == S_RESP);
   assign rsp_id        = id_q;
   assign rsp_data      = data_q;
   assign rsp_err       = err_q;
   assign eng_in_valid  = (state_q == S_ISSUE);
   assign eng_in_data_1 = rad_q;
   assign eng_in_data_2 = deg_q;
   assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_root_engine_arbiter.sv
// Self-checking bench for root_engine_arbiter. It contains a transaction-level
// model of the arbiter and a stub root engine. The model records, per accepted
// request, the cycles in which the issue and the response must occur and the
// values they must carry. A negedge compare process checks all outputs on every
// cycle against that model.
module tb_root_engine_arbiter;

   localparam int N    = 4;
   localparam int ID_W = 2;
   localparam int TO   = 16;
   localparam int RB_W = N * 10;
   localparam int DB_W = N * 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req_valid = '0;
   logic [N-1:0]     req_ready;
   logic [RB_W-1:0]  req_radicand = '0;
   logic [DB_W-1:0]  req_degree = '0;
   logic             rsp_valid;
   logic [ID_W-1:0]  rsp_id;
   logic [19:0]      rsp_data;
   logic             rsp_err;
   logic             eng_in_valid;
   logic [9:0]       eng_in_data_1;
   logic [2:0]       eng_in_data_2;
   logic             eng_out_valid = 1'b0;
   logic [19:0]      eng_out_data = '0;
   logic             busy;

   root_engine_arbiter #(.N_REQ(N), .ID_W(ID_W), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_radicand(req_radicand), .req_degree(req_degree),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .eng_in_valid(eng_in_valid), .eng_in_data_1(eng_in_data_1), .eng_in_data_2(eng_in_data_2),
      .eng_out_valid(eng_out_valid), .eng_out_data(eng_out_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference root: largest Q10.10 value y such that (y/1024)^d <= x.
   function automatic logic [19:0] root_q(input logic [9:0] x, input logic [2:0] d);
      logic [159:0] target;
      logic [159:0] p;
      logic [19:0]  y;
      logic [19:0]  t;
      if (d == 3'd0) return 20'd0;
      target = 160'(x) << (10 * int'(d));
      y = '0;
      for (int b = 19; b >= 0; b--) begin
         t = y | (20'd1 << b);
         p = 160'd1;
         for (int k = 0; k < int'(d); k++) p = p * 160'(t);
         if (p <= target) y = t;
      end
      return y;
   endfunction

   // Transaction-level model state.
   int          cyc = 0;
   int          t_acc = -100;
   int          resp_at = -100;
   int          eng_at = -100;
   int          m_last = N - 1;
   int          m_id = 0;
   logic [9:0]  m_rad = '0;
   logic [2:0]  m_deg = '0;
   logic [19:0] m_data = '0;
   logic        m_err = 1'b0;
   logic [19:0] eng_res = '0;
   int          acc_cnt = 0;
   int          lat_next = -1;
   bit          force_silent = 1'b0;
   bit          allow_silent = 1'b0;
   bit          chk_en = 1'b0;

   logic [N-1:0] exp_ready = '0;
   logic         exp_busy = 1'b0;
   logic         exp_eiv = 1'b0;
   logic         exp_rv = 1'b0;

   // Observations gathered by the compare process.
   int          rsp_cnt = 0;
   int          eiv_cnt = 0;
   int          got_cyc = 0;
   logic [ID_W-1:0] got_id = '0;
   logic [19:0] got_data = '0;
   logic        got_err = 1'b0;
   int          grant_log[$];

   // Per-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("req_ready", 32'(req_ready), 32'(exp_ready));
         check("busy", 32'(busy), 32'(exp_busy));
         check("eng_in_valid", 32'(eng_in_valid), 32'(exp_eiv));
         check("eng_in_data_1", 32'(eng_in_data_1), 32'(m_rad));
         check("eng_in_data_2", 32'(eng_in_data_2), 32'(m_deg));
         check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
         if (exp_rv) begin
            check("rsp_id", 32'(rsp_id), 32'(m_id));
            check("rsp_data", 32'(rsp_data), 32'(m_data));
            check("rsp_err", 32'(rsp_err), 32'(m_err));
         end
         for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) grant_log.push_back(i);
         if (eng_in_valid) eiv_cnt++;
         if (rsp_valid) begin
            rsp_cnt++;
            got_id   = rsp_id;
            got_data = rsp_data;
            got_err  = rsp_err;
            got_cyc  = cyc;
         end
      end
   end

   // One clock cycle: drive inputs, derive expectations, advance the model.
   task automatic cycle(input logic [N-1:0] v, input logic [RB_W-1:0] rb, input logic [DB_W-1:0] db);
      bit         idle;
      bit         silent;
      int         w;
      int         lat;
      logic [9:0] rad;
      logic [2:0] deg;
      req_valid    = v;
      req_radicand = rb;
      req_degree   = db;
      idle = (cyc > resp_at);
      w = -1;
      exp_ready = '0;
      if (idle) begin
         for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (w < 0 && v[i]) w = i;
         end
      end
      if (w >= 0) exp_ready[w] = 1'b1;
      exp_busy = !idle;
      exp_eiv  = (cyc == t_acc + 1) && (m_deg != 3'd0);
      exp_rv   = (cyc == resp_at);
      if (cyc == eng_at) begin
         eng_out_valid = 1'b1;
         eng_out_data  = eng_res;
      end else if (idle && $urandom_range(0, 7) == 0) begin
         eng_out_valid = 1'b1;
         eng_out_data  = 20'($urandom());
      end else begin
         eng_out_valid = 1'b0;
         eng_out_data  = 20'($urandom());
      end
      @(posedge clk);
      if (w >= 0) begin
         rad = rb[w*10 +: 10];
         deg = db[w*3 +: 3];
         m_last = w;
         m_id   = w;
         m_rad  = rad;
         m_deg  = deg;
         t_acc  = cyc;
         acc_cnt++;
         silent = 1'b0;
`ifdef ROOT_ARB_TIMEOUT_EN
         silent = force_silent || (allow_silent && $urandom_range(0, 7) == 0);
`endif
         force_silent = 1'b0;
         if (deg == 3'd0) begin
            resp_at = cyc + 1;
            m_data  = '0;
            m_err   = 1'b1;
            eng_at  = -100;
         end else if (silent) begin
            resp_at = cyc + 2 + TO;
            m_data  = 20'hFFFFF;
            m_err   = 1'b1;
            eng_at  = resp_at + 1;
            eng_res = 20'($urandom());
         end else begin
            lat     = (lat_next >= 0) ? lat_next : $urandom_range(0, 5);
            eng_at  = cyc + 2 + lat;
            resp_at = eng_at + 1;
            eng_res = root_q(rad, deg);
            m_data  = eng_res;
            m_err   = 1'b0;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic idle_cycle();
      cycle('0, RB_W'({$urandom(), $urandom()}), DB_W'($urandom()));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (cyc <= resp_at && n < 100) begin
         idle_cycle();
         n++;
      end
      check("drain_bound", 32'(cyc > resp_at), 32'd1);
   endtask

   // One directed request from a single requester, waited on until answered.
   task automatic send(input int id, input logic [9:0] rad, input logic [2:0] deg);
      int base_rsp;
      int base_acc;
      int n;
      logic [N-1:0]    v;
      logic [RB_W-1:0] rb;
      logic [DB_W-1:0] db;
      base_rsp = rsp_cnt;
      base_acc = acc_cnt;
      rb = RB_W'({$urandom(), $urandom()});
      db = DB_W'($urandom());
      rb[id*10 +: 10] = rad;
      db[id*3 +: 3]   = deg;
      v = '0;
      v[id] = 1'b1;
      n = 0;
      while (acc_cnt == base_acc && n < 100) begin
         cycle(v, rb, db);
         n++;
      end
      while (rsp_cnt == base_rsp && n < 200) begin
         idle_cycle();
         n++;
      end
      check("send_done", 32'(rsp_cnt - base_rsp), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int eiv0;
      int base_rsp;
      int base_acc;
      int base_g;
      int n;
      logic [N-1:0]    v;
      logic [RB_W-1:0] rb;
      logic [DB_W-1:0] db;

      // Reset state.
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_eng_in_valid", 32'(eng_in_valid), 32'd0);
      check("reset_eng_in_data_1", 32'(eng_in_data_1), 32'd0);
      check("reset_rsp_data", 32'(rsp_data), 32'd0);
      rst = 1'b0;
      chk_en = 1'b1;

      // Pin the reference root model with hand-computed values.
      check("model_root_64_2", 32'(root_q(10'd64, 3'd2)), 32'h02000);
      check("model_root_27_3", 32'(root_q(10'd27, 3'd3)), 32'h00C00);
      check("model_root_5_1", 32'(root_q(10'd5, 3'd1)), 32'h01400);

      // Fairness: every requester always valid, eight grants.
      n = 0;
      while (grant_log.size() < 8 && n < 500) begin
         db = DB_W'($urandom()) | {N{3'b001}};
         cycle('1, RB_W'({$urandom(), $urandom()}), db);
         n++;
      end
      check("fair_count", 32'(grant_log.size() >= 8), 32'd1);
      for (int k = 0; k < 8 && k < grant_log.size(); k++) check("fair_order", 32'(grant_log[k]), 32'(k % 4));
      drain();

      // Directed single requests with literal expectations.
      eiv0 = eiv_cnt;
      send(1, 10'd64, 3'd2);
      check("r1_id", 32'(got_id), 32'd1);
      check("r1_data", 32'(got_data), 32'h02000);
      check("r1_err", 32'(got_err), 32'd0);
      check("r1_issue_once", 32'(eiv_cnt - eiv0), 32'd1);
      drain();

      send(2, 10'd27, 3'd3);
      check("r2_id", 32'(got_id), 32'd2);
      check("r2_data", 32'(got_data), 32'h00C00);
      drain();

      send(0, 10'd5, 3'd1);
      check("r0_id", 32'(got_id), 32'd0);
      check("r0_data", 32'(got_data), 32'h01400);
      drain();

      eiv0 = eiv_cnt;
      send(3, 10'd9, 3'd0);
      check("deg0_id", 32'(got_id), 32'd3);
      check("deg0_data", 32'(got_data), 32'd0);
      check("deg0_err", 32'(got_err), 32'd1);
      check("deg0_latency", 32'(got_cyc - t_acc), 32'd1);
      check("deg0_no_issue", 32'(eiv_cnt - eiv0), 32'd0);
      drain();

`ifdef ROOT_ARB_TIMEOUT_EN
      // Silent engine: the watchdog answers; the late result is discarded.
      force_silent = 1'b1;
      send(1, 10'd100, 3'd2);
      check("to_err", 32'(got_err), 32'd1);
      check("to_data", 32'(got_data), 32'hFFFFF);
      check("to_latency", 32'(got_cyc - t_acc), 32'(2 + 16));
      base_rsp = rsp_cnt;
      repeat (6) idle_cycle();
      check("to_late_ignored", 32'(rsp_cnt - base_rsp), 32'd0);
      drain();
`endif

      // Asynchronous reset in the middle of BUSY.
      lat_next = 5;
      base_acc = acc_cnt;
      rb = RB_W'({$urandom(), $urandom()});
      db = DB_W'($urandom());
      db[2*3 +: 3] = 3'd4;
      v = '0;
      v[2] = 1'b1;
      n = 0;
      while (acc_cnt == base_acc && n < 50) begin
         cycle(v, rb, db);
         n++;
      end
      lat_next = -1;
      repeat (3) idle_cycle();
      check("pre_reset_busy", 32'(busy), 32'd1);
      base_rsp = rsp_cnt;
      chk_en = 1'b0;
      eng_out_valid = 1'b0;
      req_valid = '1;
      #2 rst = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("arst_eng_in_valid", 32'(eng_in_valid), 32'd0);
      check("arst_req_ready", 32'(req_ready), 32'd0);
      check("arst_eng_in_data_1", 32'(eng_in_data_1), 32'd0);
      check("arst_eng_in_data_2", 32'(eng_in_data_2), 32'd0);
      check("arst_rsp_data", 32'(rsp_data), 32'd0);
      check("arst_rsp_id", 32'(rsp_id), 32'd0);
      @(posedge clk);
      #3 rst = 1'b0;
      t_acc   = -100;
      resp_at = -100;
      eng_at  = -100;
      m_last  = N - 1;
      m_id    = 0;
      m_rad   = '0;
      m_deg   = '0;
      m_data  = '0;
      m_err   = 1'b0;
      chk_en  = 1'b1;
      repeat (10) idle_cycle();
      check("arst_no_response", 32'(rsp_cnt - base_rsp), 32'd0);
      base_g = grant_log.size();
      n = 0;
      while (grant_log.size() == base_g && n < 20) begin
         cycle('1, RB_W'({$urandom(), $urandom()}), DB_W'($urandom()) | {N{3'b001}});
         n++;
      end
      check("arst_first_grant_seen", 32'(grant_log.size() > base_g), 32'd1);
      if (grant_log.size() > base_g) check("arst_first_grant", 32'(grant_log[base_g]), 32'd0);
      drain();

      // Randomized traffic, including withdrawn requests and stray results.
      allow_silent = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         v = N'($urandom()) & N'($urandom());
         cycle(v, RB_W'({$urandom(), $urandom()}), DB_W'($urandom()));
      end
      allow_silent = 1'b0;
      drain();
      check("random_progress", 32'(acc_cnt > 50), 32'd1);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/root_engine_arbiter.md
Name: root_engine_arbiter

Overview:
- Shares one fixed-point root engine (10-bit radicand, 3-bit degree, 20-bit Q10.10 result) among N_REQ requesters.
- Round-robin grant; operands are latched and held stable for the whole engine computation.
- Sequences the engine's in_valid/out_valid pulses and returns each result tagged with the requester ID.
- Sits between the requester clients and the single engine instance in the compute top.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of rsp_id; must equal clog2(N_REQ)
TIMEOUT_CYCLES, 1023, watchdog limit in BUSY (used only with ROOT_ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  N_REQ  per-requester request
req_ready  output  N_REQ  one-hot grant/accept, combinational
req_radicand  input  N_REQ*10  radicand, slice i = [10i+9:10i], unsigned integer
req_degree  input  N_REQ*3  root degree, slice i = [3i+2:3i]
rsp_valid  output  1  one-cycle response pulse
rsp_id  output  ID_W  index of the requester being answered
rsp_data  output  20  Q10.10 root result
rsp_err  output  1  response is an error (degree 0 or timeout)
eng_in_valid  output  1  one-cycle start pulse to the engine
eng_in_data_1  output  10  radicand to the engine, held until eng_out_valid
eng_in_data_2  output  3  degree to the engine, held until eng_out_valid
eng_out_valid  input  1  engine result strobe
eng_out_data  input  20  engine result
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; all registered outputs go to 0.
  - RR pointer resets to N_REQ-1, so requester 0 has first priority.
  - The engine's own active-low reset is driven by the top as ~rst. A reset mid-operation abandons the transaction and emits no response.
- States: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - req_ready is one-hot for the winning valid requester, searching from ptr+1 upward with wrap-around. It is all-zero if no request is valid or the state is not IDLE.
  - Accept happens in the cycle where req_valid[i] & req_ready[i] are both high (cycle T). On accept: latch radicand, degree and ID; set ptr = i.
  - If the latched degree is nonzero, go to ISSUE. If it is 0, go to RESP with err=1 and data=0; the engine is not touched.
- ISSUE (T+1):
  - eng_in_valid=1 for exactly this cycle; eng_in_data_1/2 carry the latched operands.
  - Always go to BUSY.
- BUSY:
  - eng_in_data_1/2 stay held; the watchdog counter increments.
  - On eng_out_valid, capture eng_out_data with err=0 and go to RESP.
- RESP:
  - rsp_valid=1 for one cycle with rsp_id, rsp_data and rsp_err.
  - Always return to IDLE. This guarantees at least one idle cycle before the next eng_in_valid, which the engine needs to return to its own idle state.
- No backpressure on responses; clients must sample rsp_valid when it pulses.
- eng_out_valid outside BUSY is ignored (stray result discarded).
- A requester's req_valid dropping before grant withdraws its request; a grant is never revoked once the accept cycle has passed.
- Operands are sampled only in the accept cycle. Later changes on the request bus have no effect.
- Minimum turnaround with a degree-1 engine result arriving in cycle B: accept T, issue T+1, RESP at B+1, IDLE at B+2.
- Fairness: with all requesters continuously valid, grants go 0,1,2,...,N_REQ-1,0 with no repeats.
- eng_in_data_1/2 hold their last value in IDLE; only eng_in_valid qualifies them.

Optional Feature:
- Macro ROOT_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY. If it reaches TIMEOUT_CYCLES without eng_out_valid, go to RESP with rsp_err=1 and rsp_data=20'hFFFFF.
  - A late engine result is then discarded per the stray rule.
- Not defined:
  - No counter is synthesized; BUSY waits indefinitely for eng_out_valid.
  - TIMEOUT_CYCLES is unused.

Test Plan:
- Requester 1 sends radicand 64, degree 2, with the real engine attached → one rsp_valid, rsp_id=1, rsp_data=20'h02000, rsp_err=0. eng_in_valid pulses exactly once, and eng_in_data stays stable 64/2 through BUSY.
- Requester 2 sends radicand 27, degree 3 → rsp_data=20'h00C00, rsp_id=2. Requester 0 sends radicand 5, degree 1 → rsp_data=20'h01400.
- All 4 req_valid held high for 8 transactions → grant order 0,1,2,3,0,1,2,3. req_ready is one-hot and only in IDLE; responses carry the matching IDs.
- Requester 3 sends degree 0, radicand 9 → RESP in the cycle after accept with rsp_err=1, rsp_data=0. eng_in_valid never asserts.
- Stub engine never raises eng_out_valid, TIMEOUT_CYCLES=16, macro defined → rsp_err=1, rsp_data=20'hFFFFF 16 cycles after BUSY entry. A later stub eng_out_valid produces no rsp_valid.
- Assert rst for 1 cycle, asynchronous to clk, mid-BUSY → all outputs 0 immediately and no response emitted. The next request from requester 0 is granted first and completes normally.
